canvas_centerer: RTL and testbench

CANVAS_CENTERER -- requirements
Module: canvas_centerer

---
 rtl/canvas_pkg.sv | 13 +
 rtl/bbox_tracker.sv | 59 +++++
 rtl/canvas_centerer.sv | 168 ++++++++++++++++
 tb/tb_canvas_centerer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/canvas_pkg.sv
// rtl/canvas_pkg.sv - shared canvas geometry and centerer FSM state type
package canvas_pkg;
  localparam int CANVAS_W = 32;
  localparam int CANVAS_H = 32;
  localparam int N        = CANVAS_W * CANVAS_H;
  localparam int X_W      = $clog2(CANVAS_W);
  localparam int Y_W      = $clog2(CANVAS_H);
  localparam int IDX_W    = X_W + Y_W;
  localparam int SHX_W    = X_W + 1;
  localparam int SHY_W    = Y_W + 1;

  typedef enum logic [1:0] {IDLE, SCAN, STREAM, FINISH} state_t;
endpackage

// File: rtl/bbox_tracker.sv
// rtl/bbox_tracker.sv - running min/max of ink coordinates over one scan
module bbox_tracker #(
  parameter int XW   = 5,
  parameter int YW   = 5,
  parameter int XMAX = 31,
  parameter int YMAX = 31
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          en,
  input  logic          ink,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  output logic [XW-1:0] min_x,
  output logic [XW-1:0] max_x,
  output logic [YW-1:0] min_y,
  output logic [YW-1:0] max_y
);
  logic [XW-1:0] min_x_q, min_x_d, max_x_q, max_x_d;
  logic [YW-1:0] min_y_q, min_y_d, max_y_q, max_y_d;

  always_comb begin
    min_x_d = min_x_q;
    max_x_d = max_x_q;
    min_y_d = min_y_q;
    max_y_d = max_y_q;
    if (clear) begin
      min_x_d = XW'(XMAX);
      max_x_d = '0;
      min_y_d = YW'(YMAX);
      max_y_d = '0;
    end else if (en && ink) begin
      if (x < min_x_q) min_x_d = x;
      if (x > max_x_q) max_x_d = x;
      if (y < min_y_q) min_y_d = y;
      if (y > max_y_q) max_y_d = y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_x_q <= XW'(XMAX);
      max_x_q <= '0;
      min_y_q <= YW'(YMAX);
      max_y_q <= '0;
    end else begin
      min_x_q <= min_x_d;
      max_x_q <= max_x_d;
      min_y_q <= min_y_d;
      max_y_q <= max_y_d;
    end
  end

  assign min_x = min_x_q;
  assign max_x = max_x_q;
  assign min_y = min_y_q;
  assign max_y = max_y_q;
endmodule

// File: rtl/canvas_centerer.sv
// rtl/canvas_centerer.sv - snapshot a canvas, find its ink bbox, stream it re-centered
module canvas_centerer
  import canvas_pkg::*;
#(
  parameter int CANVAS_W = canvas_pkg::CANVAS_W,
  parameter int CANVAS_H = canvas_pkg::CANVAS_H
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CANVAS_W*CANVAS_H-1:0]  canvas,
  input  logic                          empty,
  input  logic                          start,
  output logic                          busy,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic                          pix_data,
  output logic                          pix_last,
  output logic                          done,
  output logic                          blank,
  output logic [$clog2(CANVAS_W)-1:0]   bbox_min_x,
  output logic [$clog2(CANVAS_W)-1:0]   bbox_max_x,
  output logic [$clog2(CANVAS_H)-1:0]   bbox_min_y,
  output logic [$clog2(CANVAS_H)-1:0]   bbox_max_y
);
  localparam int NPIX = CANVAS_W * CANVAS_H;
  localparam int XW   = $clog2(CANVAS_W);
  localparam int YW   = $clog2(CANVAS_H);
  localparam int IW   = XW + YW;

  state_t               state_q, state_d;
  logic [IW-1:0]        cnt_q, cnt_d;
  logic [NPIX-1:0]      snap_q, snap_d;
  logic                 blank_q, blank_d;
  logic [XW-1:0]        min_x_q, min_x_d, max_x_q, max_x_d;
  logic [YW-1:0]        min_y_q, min_y_d, max_y_q, max_y_d;
  logic signed [XW:0]   shx_q, shx_d;
  logic signed [YW:0]   shy_q, shy_d;

  logic [XW-1:0]        cur_x, trk_min_x, trk_max_x, fin_max_x;
  logic [YW-1:0]        cur_y, trk_min_y, trk_max_y, fin_max_y;
  logic [XW:0]          sum_x;
  logic [YW:0]          sum_y;
  logic signed [XW:0]   shx_fin;
  logic signed [YW:0]   shy_fin;
  logic signed [XW+1:0] src_x;
  logic signed [YW+1:0] src_y;
  logic                 src_ok, cnt_last, accept;

  assign cur_x    = cnt_q[XW-1:0];
  assign cur_y    = cnt_q[IW-1:XW];
  assign cnt_last = (cnt_q == IW'(NPIX - 1));
  assign accept   = (state_q == IDLE) && start;

  bbox_tracker #(.XW(XW), .YW(YW), .XMAX(CANVAS_W - 1), .YMAX(CANVAS_H - 1)) u_bbox (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (accept && !empty),
    .en    (state_q == SCAN),
    .ink   (snap_q[cnt_q]),
    .x     (cur_x),
    .y     (cur_y),
    .min_x (trk_min_x),
    .max_x (trk_max_x),
    .min_y (trk_min_y),
    .max_y (trk_max_y)
  );

  // The final scan pixel (W-1,H-1) lands in the tracker on the exit edge itself,
  // so fold it in here; it can only raise the maxima.
  assign fin_max_x = snap_q[NPIX-1] ? XW'(CANVAS_W - 1) : trk_max_x;
  assign fin_max_y = snap_q[NPIX-1] ? YW'(CANVAS_H - 1) : trk_max_y;
  assign sum_x     = {1'b0, trk_min_x} + {1'b0, fin_max_x};
  assign sum_y     = {1'b0, trk_min_y} + {1'b0, fin_max_y};
  assign shx_fin   = $signed((XW + 1)'(CANVAS_W / 2 - 1)) - $signed({1'b0, sum_x[XW:1]});
  assign shy_fin   = $signed((YW + 1)'(CANVAS_H / 2 - 1)) - $signed({1'b0, sum_y[YW:1]});

  // Source coordinate carries two extra bits so out-of-canvas reads never wrap.
  assign src_x  = $signed({2'b00, cur_x}) - $signed({shx_q[XW], shx_q});
  assign src_y  = $signed({2'b00, cur_y}) - $signed({shy_q[YW], shy_q});
  assign src_ok = !src_x[XW+1] && (src_x[XW:0] < (XW + 1)'(CANVAS_W)) &&
                  !src_y[YW+1] && (src_y[YW:0] < (YW + 1)'(CANVAS_H));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    blank_d = blank_q;
    min_x_d = min_x_q;
    max_x_d = max_x_q;
    min_y_d = min_y_q;
    max_y_d = max_y_q;
    shx_d   = shx_q;
    shy_d   = shy_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          snap_d  = canvas;
          cnt_d   = '0;
          blank_d = empty;
          state_d = empty ? FINISH : SCAN;
        end
      end
      SCAN: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = STREAM;
          min_x_d = trk_min_x;
          max_x_d = fin_max_x;
          min_y_d = trk_min_y;
          max_y_d = fin_max_y;
          shx_d   = shx_fin;
          shy_d   = shy_fin;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STREAM: begin
        if (pix_ready) begin
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = FINISH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      snap_q  <= '0;
      blank_q <= 1'b0;
      min_x_q <= '0;
      max_x_q <= '0;
      min_y_q <= '0;
      max_y_q <= '0;
      shx_q   <= '0;
      shy_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      blank_q <= blank_d;
      min_x_q <= min_x_d;
      max_x_q <= max_x_d;
      min_y_q <= min_y_d;
      max_y_q <= max_y_d;
      shx_q   <= shx_d;
      shy_q   <= shy_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign pix_valid  = (state_q == STREAM);
  assign pix_data   = (state_q == STREAM) && src_ok && snap_q[{src_y[YW-1:0], src_x[XW-1:0]}];
  assign pix_last   = (state_q == STREAM) && cnt_last;
  assign done       = (state_q == FINISH);
  assign blank      = blank_q;
  assign bbox_min_x = min_x_q;
  assign bbox_max_x = max_x_q;
  assign bbox_min_y = min_y_q;
  assign bbox_max_y = max_y_q;
endmodule

// File: tb/tb_canvas_centerer.sv
// tb/tb_canvas_centerer.sv - randomized self-checking bench for canvas_centerer
module tb_canvas_centerer;
  localparam int W      = 32;
  localparam int H      = 32;
  localparam int N      = W * H;
  localparam int BUDGET = 4000;

  logic         clk = 1'b0;
  logic         rst_n, empty, start, pix_ready;
  logic [N-1:0] canvas_in;
  logic         busy, pix_valid, pix_data, pix_last, done, blank;
  logic [4:0]   bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y;

  int total = 0;
  int bad   = 0;

  logic [N-1:0] exp_img, got_img;
  int exp_minx, exp_maxx, exp_miny, exp_maxy;
  int nbeats, first_valid_at, done_at, lastbad;
  bit unstable, busy_dropped, stopped;

  canvas_centerer #(.CANVAS_W(W), .CANVAS_H(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .canvas     (canvas_in),
    .empty      (empty),
    .start      (start),
    .busy       (busy),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .pix_last   (pix_last),
    .done       (done),
    .blank      (blank),
    .bbox_min_x (bbox_min_x),
    .bbox_max_x (bbox_max_x),
    .bbox_min_y (bbox_min_y),
    .bbox_max_y (bbox_max_y)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int ndiff(input logic [N-1:0] a, input logic [N-1:0] b);
    int n = 0;
    for (int i = 0; i < N; i++) if (a[i] !== b[i]) n++;
    return n;
  endfunction

  // Reference: bounding box, centre shift and shifted image straight from the rules.
  task automatic model(input logic [N-1:0] c);
    int shx, shy, sx, sy;
    exp_minx = W - 1; exp_maxx = 0; exp_miny = H - 1; exp_maxy = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (c[x + W * y]) begin
          if (x < exp_minx) exp_minx = x;
          if (x > exp_maxx) exp_maxx = x;
          if (y < exp_miny) exp_miny = y;
          if (y > exp_maxy) exp_maxy = y;
        end
    shx = (W / 2 - 1) - (exp_minx + exp_maxx) / 2;
    shy = (H / 2 - 1) - (exp_miny + exp_maxy) / 2;
    for (int k = 0; k < N; k++) begin
      sx = (k % W) - shx;
      sy = (k / W) - shy;
      if (sx >= 0 && sx < W && sy >= 0 && sy < H) exp_img[k] = c[sx + W * sy];
      else exp_img[k] = 1'b0;
    end
  endtask

  task automatic rand_canvas(output logic [N-1:0] c);
    int x0, x1, y0, y1, t;
    x0 = $urandom_range(W - 1); x1 = $urandom_range(W - 1);
    y0 = $urandom_range(H - 1); y1 = $urandom_range(H - 1);
    if (x1 < x0) begin t = x0; x0 = x1; x1 = t; end
    if (y1 < y0) begin t = y0; y0 = y1; y1 = t; end
    c = '0;
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        if ($urandom_range(3) == 0) c[x + W * y] = 1'b1;
    c[x0 + W * y0] = 1'b1;
  endtask

  task automatic do_start(input logic [N-1:0] c, input logic e);
    canvas_in = c;
    empty     = e;
    start     = 1'b1;
    step();
    start     = 1'b0;
    empty     = 1'b0;
  endtask

  // Observes one operation from the sample right after start; cycle 1 is that sample.
  task automatic run_op(input int stall_pct, input int stop_at);
    int   cyc;
    bit   held;
    logic hd, hl;
    nbeats = 0; first_valid_at = 0; done_at = 0; lastbad = 0;
    unstable = 0; busy_dropped = 0; stopped = 0; got_img = '0;
    held = 0; hd = 1'b0; hl = 1'b0;
    cyc = 1;
    while (cyc <= BUDGET) begin
      if (stop_at >= 0 && nbeats == stop_at) begin
        stopped = 1;
        break;
      end
      if (done) begin
        done_at = cyc;
        break;
      end
      if (!busy) busy_dropped = 1;
      if (pix_valid) begin
        if (first_valid_at == 0) first_valid_at = cyc;
        if (held && (pix_data !== hd || pix_last !== hl)) unstable = 1;
        pix_ready = ($urandom_range(99) >= stall_pct);
        if (pix_ready) begin
          if (nbeats < N) got_img[nbeats] = pix_data;
          if (pix_last !== (nbeats == N - 1)) lastbad++;
          nbeats++;
          held = 0;
        end else begin
          held = 1; hd = pix_data; hl = pix_last;
        end
      end else begin
        pix_ready = 1'b1;
      end
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    total++; if ({busy, pix_valid, pix_data, pix_last, done, blank} !== 6'b0) begin bad++; $display("FAIL reset_ctrl got=%b want=000000", {busy, pix_valid, pix_data, pix_last, done, blank}); end
    total++; if ({bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y} !== 20'h0) begin bad++; $display("FAIL reset_bbox got=%h want=0", {bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y}); end
    rst_n = 1'b1;
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_single_pixel();
    logic [N-1:0] c;
    c = '0;
    c[5 + W * 7] = 1'b1;
    model(c);
    do_start(c, 1'b0);
    run_op(0, -1);
    total++; if (done_at !== 2 * N + 1) begin bad++; $display("FAIL single_done_at got=%0d want=%0d", done_at, 2 * N + 1); end
    total++; if (first_valid_at !== N + 1) begin bad++; $display("FAIL single_first_valid got=%0d want=%0d", first_valid_at, N + 1); end
    total++; if (nbeats !== N) begin bad++; $display("FAIL single_beats got=%0d want=%0d", nbeats, N); end
    total++; if (lastbad !== 0) begin bad++; $display("FAIL single_last got=%0d want=0", lastbad); end
    total++; if (busy_dropped !== 1'b0) begin bad++; $display("FAIL single_busy got=%b want=0", busy_dropped); end
    total++; if (ndiff(got_img, exp_img) !== 0) begin bad++; $display("FAIL single_stream got=%0d diffs want=0", ndiff(got_img, exp_img)); end
    total++; if (got_img[15 + W * 15] !== 1'b1 || $countones(got_img) !== 1) begin bad++; $display("FAIL single_ink got=%b/%0d want=1/1", got_img[15 + W * 15], $countones(got_img)); end
    total++; if ({bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y} !== {5'd5, 5'd5, 5'd7, 5'd7}) begin bad++; $display("FAIL single_bbox got=%0d/%0d/%0d/%0d want=5/5/7/7", bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y); end
    step();
    total++; if ({busy, done, pix_valid} !== 3'b000) begin bad++; $display("FAIL single_after_done got=%b want=000", {busy, done, pix_valid}); end
  endtask

  task automatic test_box();
    logic [N-1:0] c, lit;
    c = '0; lit = '0;
    for (int y = 0; y <= 3; y++) for (int x = 20; x <= 29; x++) c[x + W * y] = 1'b1;
    for (int y = 14; y <= 17; y++) for (int x = 11; x <= 20; x++) lit[x + W * y] = 1'b1;
    model(c);
    do_start(c, 1'b0);
    run_op(0, -1);
    total++; if (done_at !== 2 * N + 1) begin bad++; $display("FAIL box_done_at got=%0d want=%0d", done_at, 2 * N + 1); end
    total++; if ({bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y} !== {5'd20, 5'd29, 5'd0, 5'd3}) begin bad++; $display("FAIL box_bbox got=%0d/%0d/%0d/%0d want=20/29/0/3", bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y); end
    total++; if (ndiff(got_img, lit) !== 0) begin bad++; $display("FAIL box_literal got=%0d diffs want=0", ndiff(got_img, lit)); end
    total++; if (ndiff(got_img, exp_img) !== 0) begin bad++; $display("FAIL box_model got=%0d diffs want=0", ndiff(got_img, exp_img)); end
    step();
  endtask

  task automatic test_blank();
    logic [N-1:0] c;
    bit vseen;
    rand_canvas(c);
    do_start(c, 1'b1);
    vseen = pix_valid;
    total++; if ({done, blank} !== 2'b11) begin bad++; $display("FAIL blank_done got=%b want=11", {done, blank}); end
    total++; if ({bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y} !== {5'd20, 5'd29, 5'd0, 5'd3}) begin bad++; $display("FAIL blank_bbox got=%0d/%0d/%0d/%0d want=20/29/0/3", bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y); end
    step();
    vseen = vseen | pix_valid;
    total++; if ({busy, done, blank} !== 3'b001) begin bad++; $display("FAIL blank_after got=%b want=001", {busy, done, blank}); end
    total++; if (vseen !== 1'b0) begin bad++; $display("FAIL blank_valid got=%b want=0", vseen); end
  endtask

  task automatic test_random_stall();
    logic [N-1:0] c;
    for (int r = 0; r < 2; r++) begin
      rand_canvas(c);
      model(c);
      do_start(c, 1'b0);
      total++; if (blank !== 1'b0) begin bad++; $display("FAIL stall_blank_clr got=%b want=0", blank); end
      run_op(50, -1);
      total++; if (done_at == 0) begin bad++; $display("FAIL stall_timeout got=%0d want=nonzero", done_at); end
      total++; if (nbeats !== N) begin bad++; $display("FAIL stall_beats got=%0d want=%0d", nbeats, N); end
      total++; if (unstable !== 1'b0) begin bad++; $display("FAIL stall_stable got=%b want=0", unstable); end
      total++; if (lastbad !== 0) begin bad++; $display("FAIL stall_last got=%0d want=0", lastbad); end
      total++; if (ndiff(got_img, exp_img) !== 0) begin bad++; $display("FAIL stall_stream got=%0d diffs want=0", ndiff(got_img, exp_img)); end
      total++; if (bbox_min_x !== exp_minx[4:0] || bbox_max_x !== exp_maxx[4:0] || bbox_min_y !== exp_miny[4:0] || bbox_max_y !== exp_maxy[4:0]) begin bad++; $display("FAIL stall_bbox got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d", bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y, exp_minx, exp_maxx, exp_miny, exp_maxy); end
      step();
    end
  endtask

  task automatic test_reset_mid_stream();
    logic [N-1:0] c;
    rand_canvas(c);
    do_start(c, 1'b0);
    run_op(0, 300);
    total++; if (stopped !== 1'b1) begin bad++; $display("FAIL mid_reach300 got=%b want=1", stopped); end
    rst_n = 1'b0;
    #1;
    total++; if ({busy, pix_valid, pix_data, pix_last, done, blank} !== 6'b0) begin bad++; $display("FAIL mid_reset_ctrl got=%b want=000000", {busy, pix_valid, pix_data, pix_last, done, blank}); end
    total++; if ({bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y} !== 20'h0) begin bad++; $display("FAIL mid_reset_bbox got=%h want=0", {bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y}); end
    step();
    rst_n = 1'b1;
    step();
    rand_canvas(c);
    model(c);
    do_start(c, 1'b0);
    run_op(0, -1);
    total++; if (done_at !== 2 * N + 1) begin bad++; $display("FAIL mid_restart_done got=%0d want=%0d", done_at, 2 * N + 1); end
    total++; if (nbeats !== N) begin bad++; $display("FAIL mid_restart_beats got=%0d want=%0d", nbeats, N); end
    total++; if (ndiff(got_img, exp_img) !== 0) begin bad++; $display("FAIL mid_restart_stream got=%0d diffs want=0", ndiff(got_img, exp_img)); end
    step();
  endtask

  task automatic test_snapshot();
    logic [N-1:0] a, b;
    rand_canvas(a);
    b = ~a;
    model(a);
    do_start(a, 1'b0);
    repeat (10) step();
    canvas_in = b;
    start = 1'b1;
    step();
    start = 1'b0;
    run_op(0, -1);
    total++; if (done_at !== 2 * N + 1 - 11) begin bad++; $display("FAIL snap_done_at got=%0d want=%0d", done_at, 2 * N + 1 - 11); end
    total++; if (ndiff(got_img, exp_img) !== 0) begin bad++; $display("FAIL snap_stream got=%0d diffs want=0", ndiff(got_img, exp_img)); end
    total++; if (bbox_min_x !== exp_minx[4:0] || bbox_max_x !== exp_maxx[4:0] || bbox_min_y !== exp_miny[4:0] || bbox_max_y !== exp_maxy[4:0]) begin bad++; $display("FAIL snap_bbox got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d", bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y, exp_minx, exp_maxx, exp_miny, exp_maxy); end
    start = 1'b1;
    step();
    start = 1'b0;
    total++; if ({busy, pix_valid} !== 2'b00) begin bad++; $display("FAIL snap_start_on_done got=%b want=00", {busy, pix_valid}); end
    step();
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL snap_stays_idle got=%b want=00", {busy, done}); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; empty = 1'b0; pix_ready = 1'b0; canvas_in = '0;
    test_reset();
    test_single_pixel();
    test_box();
    test_blank();
    test_random_stall();
    test_reset_mid_stream();
    test_snapshot();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
